// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared state encoding and AXI constants for the write-burst master
package axi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } wr_state_e;

  localparam logic [1:0] BURST_INCR     = 2'b01;
  localparam logic [1:0] RESP_OKAY      = 2'b00;
  localparam logic [1:0] RESP_SLVERR    = 2'b10;
  localparam int         TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/axi_wr_fifo.sv
// rtl/axi_wr_fifo.sv - synchronous write-data FIFO with registered pointers and flush
module axi_wr_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  logic                  axi_ACLK,
  input  logic                  axi_ARESETn,
  input  logic                  flush,
  input  logic                  in_tvalid,
  output logic                  in_tready,
  input  logic [DATA_WIDTH-1:0] in_tdata,
  output logic                  out_tvalid,
  input  logic                  out_tready,
  output logic [DATA_WIDTH-1:0] out_tdata
);

  localparam int PW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW:0]           wr_ptr;
  logic [PW:0]           rd_ptr;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

  assign in_tready  = !full;
  assign out_tvalid = !empty;
  assign out_tdata  = mem[rd_ptr[PW-1:0]];

  assign push = in_tvalid && !full;
  assign pop  = out_tready && !empty;

  always_ff @(posedge axi_ACLK or negedge axi_ARESETn) begin
    if (!axi_ARESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  always_ff @(posedge axi_ACLK) begin
    if (push) mem[wr_ptr[PW-1:0]] <= in_tdata;
  end

endmodule

// File: rtl/axi_wr_burst_master.sv
// rtl/axi_wr_burst_master.sv - single-outstanding AXI4 INCR write-burst master; optional watchdog via AXI_WR_MASTER_TIMEOUT_EN
module axi_wr_burst_master
  import axi_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 8,
  parameter int ID_WIDTH   = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                    axi_ACLK,
  input  logic                    axi_ARESETn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [LEN_WIDTH-1:0]    cmd_len,
  input  logic [ID_WIDTH-1:0]     cmd_id,
  input  logic                    wd_valid,
  output logic                    wd_ready,
  input  logic [DATA_WIDTH-1:0]   wd_data,
  output logic                    done_valid,
  output logic [1:0]              done_resp,
  output logic                    axi_AWVALID,
  input  logic                    axi_AWREADY,
  output logic [ID_WIDTH-1:0]     axi_AWID,
  output logic [ADDR_WIDTH-1:0]   axi_AWADDR,
  output logic [LEN_WIDTH-1:0]    axi_AWLEN,
  output logic [2:0]              axi_AWSIZE,
  output logic [1:0]              axi_AWBURST,
  output logic                    axi_WVALID,
  input  logic                    axi_WREADY,
  output logic [DATA_WIDTH-1:0]   axi_WDATA,
  output logic [DATA_WIDTH/8-1:0] axi_WSTRB,
  output logic                    axi_WLAST,
  input  logic                    axi_BVALID,
  output logic                    axi_BREADY,
  input  logic [1:0]              axi_BRESP
);

  localparam int         STROBE_WIDTH = DATA_WIDTH / 8;
  localparam logic [2:0] AW_SIZE      = 3'($clog2(STROBE_WIDTH));

  wr_state_e             state;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [LEN_WIDTH-1:0]  aw_len;
  logic [ID_WIDTH-1:0]   aw_id;
  logic [LEN_WIDTH-1:0]  beat_cnt;
  logic                  fifo_valid;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  cmd_hs;
  logic                  aw_hs;
  logic                  w_hs;
  logic                  b_hs;
  logic                  timeout_hit;

  assign cmd_ready   = (state == ST_IDLE);
  assign axi_AWVALID = (state == ST_ADDR);
  assign axi_WVALID  = (state == ST_DATA) && fifo_valid;
  assign axi_WLAST   = axi_WVALID && (beat_cnt == aw_len);
  assign axi_BREADY  = (state == ST_RESP);

  assign axi_AWADDR  = aw_addr;
  assign axi_AWLEN   = aw_len;
  assign axi_AWID    = aw_id;
  assign axi_AWSIZE  = AW_SIZE;
  assign axi_AWBURST = BURST_INCR;
  assign axi_WDATA   = fifo_data;
  assign axi_WSTRB   = '1;

  assign cmd_hs = cmd_valid && cmd_ready;
  assign aw_hs  = axi_AWVALID && axi_AWREADY;
  assign w_hs   = axi_WVALID && axi_WREADY;
  assign b_hs   = axi_BVALID && axi_BREADY;

`ifdef AXI_WR_MASTER_TIMEOUT_EN
  logic [15:0] idle_cnt;

  // Counts cycles without progress while a burst is in flight.
  always_ff @(posedge axi_ACLK or negedge axi_ARESETn) begin
    if (!axi_ARESETn) begin
      idle_cnt <= '0;
    end else if (state == ST_IDLE || cmd_hs || aw_hs || w_hs || b_hs) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 16'd1;
    end
  end

  assign timeout_hit = (state != ST_IDLE) && !(aw_hs || w_hs || b_hs) &&
                       (idle_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  axi_wr_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .axi_ACLK    (axi_ACLK),
    .axi_ARESETn (axi_ARESETn),
    .flush       (timeout_hit),
    .in_tvalid   (wd_valid),
    .in_tready   (wd_ready),
    .in_tdata    (wd_data),
    .out_tvalid  (fifo_valid),
    .out_tready  (w_hs),
    .out_tdata   (fifo_data)
  );

  always_ff @(posedge axi_ACLK or negedge axi_ARESETn) begin
    if (!axi_ARESETn) begin
      state      <= ST_IDLE;
      aw_addr    <= '0;
      aw_len     <= '0;
      aw_id      <= '0;
      beat_cnt   <= '0;
      done_valid <= 1'b0;
      done_resp  <= RESP_OKAY;
    end else begin
      done_valid <= 1'b0;
      if (timeout_hit) begin
        state      <= ST_IDLE;
        done_valid <= 1'b1;
        done_resp  <= RESP_SLVERR;
      end else begin
        case (state)
          ST_IDLE: begin
            if (cmd_hs) begin
              aw_addr  <= cmd_addr;
              aw_len   <= cmd_len;
              aw_id    <= cmd_id;
              beat_cnt <= '0;
              state    <= ST_ADDR;
            end
          end
          ST_ADDR: begin
            if (aw_hs) state <= ST_DATA;
          end
          ST_DATA: begin
            if (w_hs) begin
              if (axi_WLAST) state <= ST_RESP;
              else           beat_cnt <= beat_cnt + LEN_WIDTH'(1);
            end
          end
          ST_RESP: begin
            if (b_hs) begin
              done_valid <= 1'b1;
              done_resp  <= axi_BRESP;
              state      <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
